// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  localparam int unsigned IFETCH_ADDR_W  = 32;
  localparam int unsigned IFETCH_INSTR_W = 32;
  localparam int unsigned PC_STEP        = 4;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    FLUSH
  } ifetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; storage is reset so the head reads zero out of reset.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Pointer, count and storage update; clear wins over push/pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Overflow is a protocol error upstream: the word is dropped.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !clear && full && !pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues credit-limited word fetches, buffers
// responses for decode and squashes in-flight words after a redirect.
// Optional feature macro IFETCH_BYPASS_EN: zero-latency response-to-decode bypass when
// the buffer is empty.
module instr_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IFETCH_ADDR_W,
  parameter int unsigned       INSTR_W  = IFETCH_INSTR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int unsigned      CntW   = $clog2(DEPTH) + 1;
  localparam logic [CntW:0]    DepthC = (CntW + 1)'(DEPTH);

  ifetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CntW-1:0]     inflight_q, inflight_d;
  logic [CntW-1:0]     drop_q, drop_d;

  logic                req_fire, rsp_live, rsp_drop, rsp_keep;
  logic [CntW:0]       credit;

  logic                buf_push, buf_pop, buf_full, buf_empty;
  logic [CntW-1:0]     buf_count;
  logic [ADDR_W+INSTR_W-1:0] buf_rdata;
  logic [ADDR_W-1:0]   pcq_rdata;
  logic                pcq_full, pcq_empty;
  logic [CntW-1:0]     pcq_count;

  assign credit         = {1'b0, inflight_q} + {1'b0, buf_count};
  assign imem_req_valid = (state_q == FETCH) && (credit < DepthC);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
  assign rsp_live       = imem_rsp_valid && (inflight_q != '0);
  assign rsp_drop       = rsp_live && ((drop_q != '0) || redirect_valid);
  assign rsp_keep       = rsp_live && !rsp_drop;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state: redirect overrides everything; FLUSH waits out the stale responses.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CntW'(req_fire) - CntW'(rsp_live);
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~ADDR_W'(3);
      // Everything still outstanding after this cycle is stale (the squashed request
      // included). Outside FLUSH drop_q is zero, so this equals drop + inflight + fire - rsp;
      // inside FLUSH it avoids counting the same words twice.
      drop_d  = inflight_d;
      state_d = (inflight_d != '0) ? FLUSH : FETCH;
    end else begin
      unique case (state_q)
        BOOT:  state_d = FETCH;
        FETCH: if (req_fire) pc_d = pc_q + ADDR_W'(PC_STEP);
        FLUSH: begin
          if (rsp_live) drop_d = drop_q - CntW'(1);
          if (drop_d == '0) state_d = FETCH;
        end
        default: state_d = BOOT;
      endcase
    end
  end

  // Buffer control and decode-side outputs.
  always_comb begin
    buf_push    = rsp_keep;
    buf_pop     = instr_ready && !buf_empty;
    instr_valid = !buf_empty;
    instr       = buf_rdata[INSTR_W-1:0];
    instr_pc    = buf_rdata[ADDR_W+INSTR_W-1:INSTR_W];
`ifdef IFETCH_BYPASS_EN
    if (buf_empty && rsp_keep) begin
      instr_valid = 1'b1;
      instr       = imem_rsp_data;
      instr_pc    = pcq_rdata;
      buf_push    = !instr_ready;
    end
`endif
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + INSTR_W)
  ) u_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (buf_push),
    .pop     (buf_pop),
    .clear   (redirect_valid),
    .wdata   ({pcq_rdata, imem_rsp_data}),
    .rdata   (buf_rdata),
    .full    (buf_full),
    .empty   (buf_empty),
    .count   (buf_count)
  );

  // Address of each outstanding request, consumed in order by its response.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W)
  ) u_pcq (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (req_fire),
    .pop     (rsp_keep),
    .clear   (redirect_valid),
    .wdata   (pc_q),
    .rdata   (pcq_rdata),
    .full    (pcq_full),
    .empty   (pcq_empty),
    .count   (pcq_count)
  );

  a_pcq_tracks: assert property (@(posedge clock) disable iff (!reset_n)
    (drop_q == '0) |-> (pcq_count == inflight_q));
  a_keep_has_pc: assert property (@(posedge clock) disable iff (!reset_n)
    rsp_keep |-> !pcq_empty);
  a_credit: assert property (@(posedge clock) disable iff (!reset_n)
    (credit <= DepthC) && !(buf_full && inflight_q != '0) && !(pcq_full && !buf_empty));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small in-order memory responder.
module tb_instr_fetch_unit;

`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int          checks = 0;
  int          errors = 0;
  bit          auto_rsp;
  logic [31:0] pend[$];
  int          fires;

  always #5 clock = ~clock;

  instr_fetch_unit u_dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record accepted requests, retire consumed responses, then drive the
  // next response (1-cycle latency) when the responder is in automatic mode.
  task automatic tick();
    if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
    if (imem_req_valid && imem_req_ready) pend.push_back(imem_req_addr);
    @(posedge clock);
    #1;
    if (auto_rsp && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(pend[0]);
    end else begin
      imem_rsp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic wait_instr(input int lim);
    int n = 0;
    while (!instr_valid && n < lim) begin
      tick();
      n++;
    end
    chk("wait_instr_valid", 64'(instr_valid), 64'd1);
  endtask

  // Reset across two edges; returns in cycle 0 after release (state BOOT).
  task automatic do_reset();
    reset_n        = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    auto_rsp       = 1'b1;
    pend.delete();
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n        = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    auto_rsp       = 1'b1;
    #1;
    chk("rst_req_valid",   64'(imem_req_valid), 64'd0);
    chk("rst_req_addr",    64'(imem_req_addr),  64'd0);
    chk("rst_instr_valid", 64'(instr_valid),    64'd0);
    chk("rst_instr",       64'(instr),          64'd0);
    chk("rst_instr_pc",    64'(instr_pc),       64'd0);

    // 1: streaming fetch from reset
    do_reset();
    chk("t1_boot_noreq", 64'(imem_req_valid), 64'd0);
    tick();
    chk("t1_fetch_req",  64'(imem_req_valid), 64'd1);
    chk("t1_addr0",      64'(imem_req_addr),  64'd0);
    tick();
    chk("t1_addr4",      64'(imem_req_addr),  64'd4);
    chk("t1_first_lat",  64'(instr_valid),    64'(BYP));
    if (!BYP) tick();
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", 64'(instr_valid), 64'd1);
      chk("t1_pc",    64'(instr_pc),    64'(4 * k));
      chk("t1_data",  64'(instr),       64'(mdata(32'(4 * k))));
      tick();
    end

    // 2: decode stalled, credit limit, then drain
    do_reset();
    instr_ready = 1'b0;
    fires = 0;
    for (int k = 0; k < 12; k++) begin
      if (imem_req_valid && imem_req_ready) fires++;
      tick();
    end
    chk("t2_fire_count",  64'(fires),          64'd4);
    chk("t2_req_stopped", 64'(imem_req_valid), 64'd0);
    chk("t2_next_addr",   64'(imem_req_addr),  64'h10);
    instr_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_instr(4);
      chk("t2_pc",   64'(instr_pc), 64'(4 * k));
      chk("t2_data", 64'(instr),    64'(mdata(32'(4 * k))));
      tick();
    end

    // 3: redirect with two requests in flight
    do_reset();
    auto_rsp = 1'b0;
    tick();
    tick();
    tick();
    imem_req_ready = 1'b0;
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #1;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t3_flush_noreq", 64'(imem_req_valid), 64'd0);
    chk("t3_new_pc",      64'(imem_req_addr),  64'h100);
    for (int k = 0; k < 2; k++) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(pend[0]);
      #1;
      chk("t3_stale_hidden", 64'(instr_valid), 64'd0);
      tick();
      chk("t3_stale_gone",   64'(instr_valid), 64'd0);
    end
    chk("t3_resume_req",  64'(imem_req_valid), 64'd1);
    chk("t3_resume_addr", 64'(imem_req_addr),  64'h100);
    auto_rsp       = 1'b1;
    imem_req_ready = 1'b1;
    #1;
    wait_instr(8);
    chk("t3_pc",   64'(instr_pc), 64'h100);
    chk("t3_data", 64'(instr),    64'(mdata(32'h100)));

    // 4: redirect coincident with a request fire and a response
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    chk("t4_redir_cycle", 64'(instr_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t4_after_redir", 64'(instr_valid),    64'd0);
    chk("t4_flush_noreq", 64'(imem_req_valid), 64'd0);
    tick();
    chk("t4_drop_done",   64'(instr_valid),    64'd0);
    chk("t4_resume_req",  64'(imem_req_valid), 64'd1);
    chk("t4_resume_addr", 64'(imem_req_addr),  64'h200);
    wait_instr(8);
    chk("t4_pc",   64'(instr_pc), 64'h200);
    chk("t4_data", 64'(instr),    64'(mdata(32'h200)));

    // 5: asynchronous reset with 3 buffered and 1 in flight
    do_reset();
    instr_ready = 1'b0;
    tick();
    tick();
    tick();
    tick();
    auto_rsp = 1'b0;
    tick();
    chk("t5_full_noreq",  64'(imem_req_valid), 64'd0);
    chk("t5_buffered",    64'(instr_valid),    64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_valid", 64'(instr_valid),    64'd0);
    chk("t5_async_instr", 64'(instr),          64'd0);
    chk("t5_async_pc",    64'(instr_pc),       64'd0);
    chk("t5_async_req",   64'(imem_req_valid), 64'd0);
    chk("t5_async_addr",  64'(imem_req_addr),  64'd0);
    @(posedge clock); #1;
    pend.delete();
    reset_n = 1'b1;
    #1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mdata(32'hC);
    #1;
    chk("t5_late_hidden", 64'(instr_valid), 64'd0);
    tick();
    chk("t5_late_gone",   64'(instr_valid),    64'd0);
    chk("t5_first_req",   64'(imem_req_valid), 64'd1);
    chk("t5_first_addr",  64'(imem_req_addr),  64'd0);
    instr_ready = 1'b1;

    // 6: response-to-instr latency with an empty buffer
    do_reset();
    tick();
    tick();
    if (BYP) begin
      chk("t6_same_cycle", 64'(instr_valid), 64'd1);
      chk("t6_data",       64'(instr),       64'(mdata(32'h0)));
    end else begin
      chk("t6_not_yet",    64'(instr_valid), 64'd0);
      tick();
      chk("t6_next_cycle", 64'(instr_valid), 64'd1);
      chk("t6_data",       64'(instr),       64'(mdata(32'h0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
